// File: rtl/spc700_brr_pkg.sv
// rtl/spc700_brr_pkg.sv - shared constants, header field positions and state encoding for the BRR block fetcher
package spc700_brr_pkg;

    localparam int BRR_BLOCK_BYTES = 9;
    localparam int BRR_NIBBLES     = 16;

    localparam int HDR_RANGE_MSB  = 7;
    localparam int HDR_RANGE_LSB  = 4;
    localparam int HDR_FILTER_MSB = 3;
    localparam int HDR_FILTER_LSB = 2;
    localparam int HDR_LOOP_BIT   = 1;
    localparam int HDR_END_BIT    = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DRAIN,
        ST_STREAM,
        ST_DONE
    } brr_state_t;

endpackage

// File: rtl/brr_nibble_serializer.sv
// rtl/brr_nibble_serializer.sv - 8-byte sample buffer streamed high-nibble-first over valid/ready
module brr_nibble_serializer
    import spc700_brr_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic       wr_en,
    input  logic [2:0] wr_index,
    input  logic [7:0] wr_data,
    input  logic       load,
    output logic [3:0] nibble,
    output logic       nibble_valid,
    input  logic       nibble_ready,
    output logic       last_accept
);

    logic [7:0] buffer [8];
    logic [3:0] index;
    logic [7:0] byte_sel;

    assign byte_sel    = buffer[index[3:1]];
    assign nibble      = !nibble_valid ? 4'h0 : (index[0] ? byte_sel[3:0] : byte_sel[7:4]);
    assign last_accept = nibble_valid && nibble_ready && (index == 4'(BRR_NIBBLES - 1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 8; i++) buffer[i] <= 8'h00;
            index        <= 4'd0;
            nibble_valid <= 1'b0;
        end else begin
            if (wr_en) buffer[wr_index] <= wr_data;
            if (load) begin
                nibble_valid <= 1'b1;
                index        <= 4'd0;
            end else if (nibble_valid && nibble_ready) begin
                if (last_accept) nibble_valid <= 1'b0;
                index <= index + 4'd1;
            end
        end
    end

endmodule

// File: rtl/brr_block_fetcher.sv
// rtl/brr_block_fetcher.sv - audio RAM read master fetching one 9-byte BRR block and streaming its nibbles
// Optional chaining to the next/loop block enabled by BRR_AUTO_CONTINUE_EN.
module brr_block_fetcher
    import spc700_brr_pkg::*;
#(
    parameter int READ_LATENCY = 1,
    parameter int ADDRESS_BITS = 16
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic [ADDRESS_BITS-1:0] start_address,
    input  logic [ADDRESS_BITS-1:0] loop_address,
    output logic [ADDRESS_BITS-1:0] ram_address,
    output logic                    ram_read,
    input  logic [7:0]              ram_data,
    output logic                    busy,
    output logic [7:0]              header,
    output logic                    header_valid,
    output logic [3:0]              nibble,
    output logic                    nibble_valid,
    input  logic                    nibble_ready,
    output logic                    block_done,
    output logic [ADDRESS_BITS-1:0] next_address
);

    brr_state_t              state;
    logic [ADDRESS_BITS-1:0] base;
    logic [3:0]              issue_cnt;
    logic [3:0]              cap_idx;
    logic [READ_LATENCY-1:0] rd_pipe;
    logic                    cap_en;
    logic                    cap_last;
    logic                    last_accept;
    logic                    launch;
    logic [ADDRESS_BITS-1:0] launch_addr;

    // A request's data is valid once its ram_read has walked the full latency pipe.
    assign cap_en   = rd_pipe[READ_LATENCY-1];
    assign cap_last = cap_en && (cap_idx == 4'(BRR_BLOCK_BYTES - 1));

`ifndef BRR_AUTO_CONTINUE_EN
    logic unused_loop;
    assign unused_loop = ^loop_address;
`endif

    always_comb begin
        launch      = 1'b0;
        launch_addr = start_address;
        if (state == ST_IDLE) begin
            launch = start;
        end
`ifdef BRR_AUTO_CONTINUE_EN
        else if (state == ST_DONE) begin
            launch      = !header[HDR_END_BIT] || header[HDR_LOOP_BIT];
            launch_addr = header[HDR_END_BIT] ? loop_address : next_address;
        end
`endif
    end

    brr_nibble_serializer u_serializer (
        .clock        (clock),
        .reset_n      (reset_n),
        .wr_en        (cap_en && (cap_idx != 4'd0)),
        .wr_index     (3'(cap_idx - 4'd1)),
        .wr_data      (ram_data),
        .load         (cap_last),
        .nibble       (nibble),
        .nibble_valid (nibble_valid),
        .nibble_ready (nibble_ready),
        .last_accept  (last_accept)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            base         <= '0;
            issue_cnt    <= 4'd0;
            cap_idx      <= 4'd0;
            rd_pipe      <= '0;
            ram_address  <= '0;
            ram_read     <= 1'b0;
            busy         <= 1'b0;
            header       <= 8'h00;
            header_valid <= 1'b0;
            block_done   <= 1'b0;
            next_address <= '0;
        end else begin
            rd_pipe <= (rd_pipe << 1) | READ_LATENCY'(ram_read);
            if (cap_en) begin
                if (cap_idx == 4'd0) begin
                    header       <= ram_data;
                    header_valid <= 1'b1;
                end
                cap_idx <= cap_last ? 4'd0 : cap_idx + 4'd1;
            end

            if (launch) begin
                base         <= launch_addr;
                ram_address  <= launch_addr;
                ram_read     <= 1'b1;
                issue_cnt    <= 4'd1;
                cap_idx      <= 4'd0;
                header_valid <= 1'b0;
                busy         <= 1'b1;
                block_done   <= 1'b0;
                state        <= ST_FETCH;
            end else begin
                case (state)
                    ST_IDLE: ;
                    ST_FETCH: begin
                        if (issue_cnt == 4'(BRR_BLOCK_BYTES)) begin
                            ram_read <= 1'b0;
                            state    <= ST_DRAIN;
                        end else begin
                            ram_address <= ram_address + 1'b1;
                            issue_cnt   <= issue_cnt + 4'd1;
                        end
                    end
                    ST_DRAIN: begin
                        if (cap_last) state <= ST_STREAM;
                    end
                    ST_STREAM: begin
                        if (last_accept) begin
                            block_done   <= 1'b1;
                            next_address <= base + ADDRESS_BITS'(BRR_BLOCK_BYTES);
                            state        <= ST_DONE;
                        end
                    end
                    ST_DONE: begin
                        block_done   <= 1'b0;
                        header_valid <= 1'b0;
                        busy         <= 1'b0;
                        state        <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_brr_block_fetcher.sv
// tb/tb_brr_block_fetcher.sv - directed self-checking bench for brr_block_fetcher
module tb_brr_block_fetcher;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] start_address = 16'h0000;
    logic [15:0] loop_address = 16'h0000;
    logic [15:0] ram_address;
    logic        ram_read;
    logic [7:0]  ram_data = 8'h00;
    logic        busy;
    logic [7:0]  header;
    logic        header_valid;
    logic [3:0]  nibble;
    logic        nibble_valid;
    logic        nibble_ready = 1'b1;
    logic        block_done;
    logic [15:0] next_address;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int start_cyc = 0;
    logic [7:0]  mem [0:65535];
    logic [3:0]  exp_nib [16];
    logic [15:0] read_log [$];

    brr_block_fetcher #(.READ_LATENCY(1), .ADDRESS_BITS(16)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .start        (start),
        .start_address(start_address),
        .loop_address (loop_address),
        .ram_address  (ram_address),
        .ram_read     (ram_read),
        .ram_data     (ram_data),
        .busy         (busy),
        .header       (header),
        .header_valid (header_valid),
        .nibble       (nibble),
        .nibble_valid (nibble_valid),
        .nibble_ready (nibble_ready),
        .block_done   (block_done),
        .next_address (next_address)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        cyc++;
        if (ram_read) read_log.push_back(ram_address);
        ram_data <= mem[ram_address];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load_block(input logic [15:0] a, input logic [71:0] blk);
        for (int i = 0; i < 9; i++) mem[16'(a + 16'(i))] = blk[71 - 8*i -: 8];
    endtask

    task automatic launch(input logic [15:0] a);
        read_log.delete();
        start_address = a;
        start = 1'b1;
        start_cyc = cyc;
        @(negedge clock);
        start = 1'b0;
        check("first_ram_address", ram_address, a);
        check("first_ram_read", ram_read, 1);
        check("busy_after_start", busy, 1);
    endtask

    task automatic run_block(input logic [15:0] base, input logic [7:0] hdr, input int mode,
                             input bit stray, input bit timing);
        int n = 0;
        int t = 0;
        int c = 0;
        int first = -1;
        bit seen = 0;
        logic [15:0] nxt;
        nxt = base + 16'd9;
        while (n < 16 && c < 300) begin
            @(negedge clock);
            c++;
            start = 1'b0;
            if (nibble_valid) begin
                if (!seen) begin
                    seen = 1;
                    first = cyc - start_cyc - 1;
                    check("header", header, hdr);
                    check("header_valid", header_valid, 1);
                end
                check("nibble", nibble, exp_nib[n]);
                nibble_ready = (mode == 0) ? 1'b1 : (t % 3 == 0);
                t++;
                if (nibble_ready) n++;
                if (stray && n == 5 && nibble_ready) begin
                    start = 1'b1;
                    start_address = 16'h2000;
                end
            end else if (seen) begin
                check("valid_held", nibble_valid, 1);
            end
        end
        check("transfer_count", n, 16);
        @(negedge clock);
        start = 1'b0;
        nibble_ready = 1'b1;
        check("block_done", block_done, 1);
        check("valid_in_done", nibble_valid, 0);
        check("next_address", next_address, nxt);
        if (timing) begin
            check("first_valid_edge", first, 10);
            check("block_done_edge", cyc - start_cyc - 1, 26);
        end
    endtask

    task automatic check_reads(input logic [15:0] base);
        check("read_count", read_log.size(), 9);
        for (int i = 0; i < 9 && i < read_log.size(); i++)
            check("read_address", read_log[i], 16'(base + 16'(i)));
    endtask

    task automatic check_idle();
        @(negedge clock);
        check("done_pulse_width", block_done, 0);
        check("busy_idle", busy, 0);
        check("header_valid_idle", header_valid, 0);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        load_block(16'h1000, 72'hB0_12_34_56_78_9A_BC_DE_F0);
        for (int i = 0; i < 16; i++) exp_nib[i] = 4'(i + 1);

        repeat (2) @(negedge clock);
        check("reset_ram_read", ram_read, 0);
        check("reset_ram_address", ram_address, 0);
        check("reset_busy", busy, 0);
        check("reset_nibble_valid", nibble_valid, 0);
        check("reset_next_address", next_address, 0);
        reset_n = 1'b1;
        @(negedge clock);

`ifdef BRR_AUTO_CONTINUE_EN
        load_block(16'h1000, 72'h00_12_34_56_78_9A_BC_DE_F0);
        load_block(16'h1009, 72'h03_12_34_56_78_9A_BC_DE_F0);
        loop_address = 16'h1000;
        launch(16'h1000);
        run_block(16'h1000, 8'h00, 0, 0, 1);
        run_block(16'h1009, 8'h03, 0, 0, 0);
        run_block(16'h1000, 8'h00, 0, 0, 0);
        check("chain_busy", busy, 1);
        check("chain_read_count", read_log.size(), 27);
        check("chain_base1", read_log[9], 16'h1009);
        check("chain_base2", read_log[18], 16'h1000);
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        mem[16'h1009] = 8'h01;
        @(negedge clock);
        launch(16'h1000);
        run_block(16'h1000, 8'h00, 0, 0, 0);
        run_block(16'h1009, 8'h01, 0, 0, 0);
        check_idle();
        check("end_read_count", read_log.size(), 18);
`else
        launch(16'h1000);
        run_block(16'h1000, 8'hB0, 0, 0, 1);
        check_reads(16'h1000);
        check_idle();

        launch(16'h1000);
        run_block(16'h1000, 8'hB0, 1, 0, 0);
        check_reads(16'h1000);
        check_idle();

        load_block(16'hFFFB, 72'h4C_01_23_45_67_89_AB_CD_EF);
        for (int i = 0; i < 16; i++) exp_nib[i] = 4'(i);
        launch(16'hFFFB);
        run_block(16'hFFFB, 8'h4C, 0, 0, 0);
        check_reads(16'hFFFB);
        check_idle();

        for (int i = 0; i < 16; i++) exp_nib[i] = 4'(i + 1);
        launch(16'h1000);
        run_block(16'h1000, 8'hB0, 0, 1, 0);
        check_reads(16'h1000);
        check_idle();

        launch(16'h1000);
        for (int i = 0; i < 12 && ram_address != 16'h1004; i++) @(negedge clock);
        check("reached_index4", ram_address, 16'h1004);
        reset_n = 1'b0;
        #1;
        check("rst_ram_address", ram_address, 0);
        check("rst_ram_read", ram_read, 0);
        check("rst_busy", busy, 0);
        check("rst_header", header, 0);
        check("rst_header_valid", header_valid, 0);
        check("rst_nibble", nibble, 0);
        check("rst_block_done", block_done, 0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        launch(16'h1000);
        run_block(16'h1000, 8'hB0, 0, 0, 1);
        check_reads(16'h1000);
        check_idle();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
